// File: rtl/tone_gen_multi.sv
// Multi-channel tone generator: per-channel note decode, step-period down-counter,
// phase index, square output and registered mix of active square bits.
module tone_gen_multi #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned NUM_OCT   = 4,
    parameter int unsigned SUBDIV    = 64,
    parameter int unsigned SYNC_MODE = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [6*NUM_CH-1:0]                  tone_in,
    input  logic [NUM_CH-1:0]                    tone_we,
    output logic [$clog2(SUBDIV)*NUM_CH-1:0]     phase,
    output logic [NUM_CH-1:0]                    step,
    output logic [NUM_CH-1:0]                    square,
    output logic [$clog2(NUM_CH+1)-1:0]          mix,
    output logic [NUM_CH-1:0]                    bad_tone
);

    localparam int unsigned PW       = $clog2(SUBDIV);
    localparam int unsigned CW       = 6;
    localparam int unsigned TW       = 14;
    localparam int unsigned MW       = $clog2(NUM_CH + 1);
    localparam int unsigned MAX_CODE = 12 * NUM_OCT;

    function automatic logic is_rest(input logic [CW-1:0] code);
        return (code == '0) || (code > CW'(MAX_CODE));
    endfunction

    // Step period: base-octave table entry shifted right once per octave (truncating).
    function automatic logic [TW-1:0] period_of(input logic [CW-1:0] code);
        logic [CW-1:0] idx;
        logic [CW-1:0] oct;
        logic [3:0]    semi;
        logic [TW-1:0] base;
        idx  = CW'(code - CW'(1));
        oct  = CW'(idx / CW'(12));
        semi = 4'(idx % CW'(12));
        case (semi)
            4'd0:    base = TW'(11945);
            4'd1:    base = TW'(11275);
            4'd2:    base = TW'(10642);
            4'd3:    base = TW'(10045);
            4'd4:    base = TW'(9481);
            4'd5:    base = TW'(8949);
            4'd6:    base = TW'(8446);
            4'd7:    base = TW'(7972);
            4'd8:    base = TW'(7525);
            4'd9:    base = TW'(7103);
            4'd10:   base = TW'(6704);
            default: base = TW'(6328);
        endcase
        return base >> oct;
    endfunction

    logic [CW-1:0]     pend_q  [NUM_CH];
    logic [CW-1:0]     pend_d  [NUM_CH];
    logic [CW-1:0]     act_q   [NUM_CH];
    logic [CW-1:0]     act_d   [NUM_CH];
    logic [TW-1:0]     cnt_q   [NUM_CH];
    logic [TW-1:0]     cnt_d   [NUM_CH];
    logic [PW-1:0]     phase_q [NUM_CH];
    logic [PW-1:0]     phase_d [NUM_CH];
    logic [NUM_CH-1:0] pv_q, pv_d;
    logic [NUM_CH-1:0] step_q, step_d;
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic [NUM_CH-1:0] bad_q, bad_d;
    logic [MW-1:0]     mix_q, mix_d;
    logic [NUM_CH-1:0] rest_c, wrap_c, apply_c;

    // Per-channel counter, phase and tone-apply logic.
    always_comb begin
        pv_d    = pv_q;
        step_d  = '0;
        sq_d    = '0;
        bad_d   = bad_q;
        rest_c  = '0;
        wrap_c  = '0;
        apply_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pend_d[i]  = pend_q[i];
            act_d[i]   = act_q[i];
            cnt_d[i]   = cnt_q[i];
            phase_d[i] = phase_q[i];

            rest_c[i] = is_rest(act_q[i]);
            wrap_c[i] = !rest_c[i] && (cnt_q[i] == '0) && (phase_q[i] == PW'(SUBDIV - 1));

            if (rest_c[i]) begin
                cnt_d[i]   = '0;
                phase_d[i] = '0;
            end else if (cnt_q[i] == '0) begin
                step_d[i]  = 1'b1;
                cnt_d[i]   = TW'(period_of(act_q[i]) - TW'(1));
                phase_d[i] = PW'(phase_q[i] + PW'(1));
            end else begin
                cnt_d[i] = TW'(cnt_q[i] - TW'(1));
            end

            apply_c[i] = pv_q[i] && ((SYNC_MODE == 0) || rest_c[i] || wrap_c[i]);

            // A deferred apply rides on the wrap step; otherwise the apply holds phase.
            if (apply_c[i]) begin
                act_d[i] = pend_q[i];
                pv_d[i]  = 1'b0;
                cnt_d[i] = is_rest(pend_q[i]) ? '0 : TW'(period_of(pend_q[i]) - TW'(1));
                if (!((SYNC_MODE != 0) && wrap_c[i])) begin
                    phase_d[i] = phase_q[i];
                    step_d[i]  = 1'b0;
                end
            end

            if (tone_we[i]) begin
                pend_d[i] = tone_in[6*i +: 6];
                pv_d[i]   = 1'b1;
                if (tone_in[6*i +: 6] > CW'(MAX_CODE)) begin
                    bad_d[i] = 1'b1;
                end
            end

            sq_d[i] = phase_d[i][PW-1] && !is_rest(act_d[i]);
        end
    end

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            mix_d = MW'(mix_d + MW'(sq_q[i]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                pend_q[i]  <= '0;
                act_q[i]   <= '0;
                cnt_q[i]   <= '0;
                phase_q[i] <= '0;
            end
            pv_q   <= '0;
            step_q <= '0;
            sq_q   <= '0;
            bad_q  <= '0;
            mix_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                pend_q[i]  <= pend_d[i];
                act_q[i]   <= act_d[i];
                cnt_q[i]   <= cnt_d[i];
                phase_q[i] <= phase_d[i];
            end
            pv_q   <= pv_d;
            step_q <= step_d;
            sq_q   <= sq_d;
            bad_q  <= bad_d;
            mix_q  <= mix_d;
        end
    end

    always_comb begin
        phase = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            phase[i*PW +: PW] = phase_q[i];
        end
    end

    assign step     = step_q;
    assign square   = sq_q;
    assign mix      = mix_q;
    assign bad_tone = bad_q;

endmodule
